// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The master drives the stage information and the slave returns the pipeline controls.
interface hazard_ctrl_if;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic        RegWriteM, RegWriteW;
  logic        MemReadE, BranchE, JumpE, cond_trueE;
  logic        MdStartE, MdDoneE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        PCSrcE;
  logic        StallF, StallD, StallE;
  logic        FlushD, FlushE, FlushM;
  logic        MdBusy, MdTimeout;
  logic [15:0] StallCount, FlushCount;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW,
    output MemReadE, BranchE, JumpE, cond_trueE,
    output MdStartE, MdDoneE,
    input  ForwardAE, ForwardBE, PCSrcE,
    input  StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM,
    input  MdBusy, MdTimeout, StallCount, FlushCount
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW,
    input  MemReadE, BranchE, JumpE, cond_trueE,
    input  MdStartE, MdDoneE,
    output ForwardAE, ForwardBE, PCSrcE,
    output StallF, StallD, StallE,
    output FlushD, FlushE, FlushM,
    output MdBusy, MdTimeout, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// mul/div stall with watchdog, and saturating stall/flush event counters.
//
// state   | meaning
// IDLE    | no mul/div in flight; MdDoneE ignored
// BUSY    | mul/div in flight; pipeline held until MdDoneE or watchdog expiry
module hazard_ctrl (
  input  logic clk,
  input  logic rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]  state;
  logic [5:0]  md_cnt;
  logic        md_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  logic        md_busy;
  logic        load_use;
  logic        redirect;
  logic        stall_f;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);
  assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RegWriteM, hz.RdM, hz.RegWriteW, hz.RdW);

  assign md_busy  = ((state == ST_IDLE) && hz.MdStartE) ||
                    ((state == ST_BUSY) && !hz.MdDoneE);
  assign load_use = hz.MemReadE && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  // A held mul/div blocks the redirect; a redirect discards ID so it beats load-use.
  assign redirect = ((hz.BranchE && hz.cond_trueE) || hz.JumpE) && !md_busy;
  assign stall_f  = md_busy || (load_use && !redirect);

  assign hz.PCSrcE     = redirect;
  assign hz.StallF     = stall_f;
  assign hz.StallD     = stall_f;
  assign hz.StallE     = md_busy;
  assign hz.FlushD     = redirect;
  assign hz.FlushE     = !md_busy && (load_use || redirect);
  assign hz.FlushM     = md_busy;
  assign hz.MdBusy     = md_busy;
  assign hz.MdTimeout  = md_timeout;
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      md_cnt     <= 6'd0;
      md_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hz.MdStartE) begin
            state  <= ST_BUSY;
            md_cnt <= 6'd0;
          end
        end
        ST_BUSY: begin
          if (hz.MdDoneE) begin
            state <= ST_IDLE;
          end else begin
            md_cnt <= md_cnt + 6'd1;
            if (md_cnt == 6'd63) begin
              state      <= ST_IDLE;
              md_timeout <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_f && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (redirect && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
endmodule
